// File: rtl/ccd_timing_gen.sv
// Linear-CCD clock generator: guarded transfer-gate pulse (sh) followed by
// continuous f1/f2/rs pixel clocking for DUMMY_NUM + PIX_NUM + line_gap periods.
module ccd_timing_gen #(
   parameter int PIX_DIV    = 20,
   parameter int RS_P_WIDTH = 2,
   parameter int SH_WIDTH   = 100,
   parameter int SH_GUARD   = 20,
   parameter int DUMMY_NUM  = 11,
   parameter int PIX_NUM    = 2048
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] line_gap,
   output logic        sh,
   output logic        f1,
   output logic        f2,
   output logic        rs,
   output logic        line_start,
   output logic        busy,
   output logic [2:0]  o_dbg_state
);

   localparam int HALF    = PIX_DIV / 2;
   localparam int PH_W    = $clog2(PIX_DIV);
   localparam int CNT_MAX = (SH_WIDTH > SH_GUARD) ? SH_WIDTH : SH_GUARD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PIX_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HALF    = PH_W'(HALF);
   localparam logic [PH_W-1:0]  PH_RS_END  = PH_W'(HALF + RS_P_WIDTH);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(SH_GUARD - 1);
   localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(SH_WIDTH - 1);
   localparam logic [17:0]      BASE_LEN   = 18'(DUMMY_NUM + PIX_NUM);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SH_PRE   = 3'd1,
      S_SH_PULSE = 3'd2,
      S_SH_POST  = 3'd3,
      S_SHIFT    = 3'd4
   } state_t;

   state_t           r_state;
   logic [PH_W-1:0]  r_ph;
   logic [CNT_W-1:0] r_cnt;
   logic [17:0]      r_pix_cnt;
   logic [15:0]      r_gap;
   logic             r_sh;
   logic             r_f1;
   logic             r_f2;
   logic             r_rs;
   logic             r_line_start;
   logic             r_busy;

   logic             w_wrap;
   logic [PH_W-1:0]  w_ph_next;
   logic             w_dec_f1;
   logic             w_dec_rs;
   logic [17:0]      w_line_len;
   logic [17:0]      w_pix_next;
   logic             w_line_end;

   assign w_wrap     = (r_ph == PH_LAST);
   assign w_ph_next  = w_wrap ? '0 : r_ph + PH_W'(1);
   assign w_dec_f1   = (r_ph < PH_HALF);
   assign w_dec_rs   = (r_ph >= PH_HALF) && (r_ph < PH_RS_END);
   assign w_line_len = BASE_LEN + {2'b00, r_gap};
   assign w_pix_next = r_pix_cnt + 18'd1;
   assign w_line_end = (w_pix_next == w_line_len);

   // Each output register is loaded from the state and phase seen at this edge,
   // so transitions into the guard states land exactly on a pixel-period boundary.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ph         <= '0;
         r_cnt        <= '0;
         r_pix_cnt    <= '0;
         r_gap        <= '0;
         r_sh         <= 1'b0;
         r_f1         <= 1'b1;
         r_f2         <= 1'b0;
         r_rs         <= 1'b0;
         r_line_start <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_line_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ph   <= w_ph_next;
               r_f1   <= w_dec_f1;
               r_f2   <= ~w_dec_f1;
               r_rs   <= w_dec_rs;
               r_sh   <= 1'b0;
               r_busy <= 1'b0;
               if (w_wrap && enable) begin
                  r_state <= S_SH_PRE;
                  r_gap   <= line_gap;
                  r_cnt   <= '0;
               end
            end
            S_SH_PRE: begin
               r_ph   <= '0;
               r_f1   <= 1'b1;
               r_f2   <= 1'b0;
               r_rs   <= 1'b0;
               r_sh   <= 1'b0;
               r_busy <= 1'b1;
               if (r_cnt == GUARD_LAST) begin
                  r_state <= S_SH_PULSE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_SH_PULSE: begin
               r_ph         <= '0;
               r_f1         <= 1'b1;
               r_f2         <= 1'b0;
               r_rs         <= 1'b0;
               r_sh         <= 1'b1;
               r_busy       <= 1'b1;
               r_line_start <= (r_cnt == '0);
               if (r_cnt == WIDTH_LAST) begin
                  r_state <= S_SH_POST;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_SH_POST: begin
               r_ph   <= '0;
               r_f1   <= 1'b1;
               r_f2   <= 1'b0;
               r_rs   <= 1'b0;
               r_sh   <= 1'b0;
               r_busy <= 1'b1;
               if (r_cnt == GUARD_LAST) begin
                  r_state   <= S_SHIFT;
                  r_cnt     <= '0;
                  r_pix_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_SHIFT: begin
               r_ph   <= w_ph_next;
               r_f1   <= w_dec_f1;
               r_f2   <= ~w_dec_f1;
               r_rs   <= w_dec_rs;
               r_sh   <= 1'b0;
               r_busy <= 1'b1;
               if (w_wrap) begin
                  if (w_line_end) begin
                     r_pix_cnt <= '0;
                     r_cnt     <= '0;
                     if (enable) begin
                        r_state <= S_SH_PRE;
                        r_gap   <= line_gap;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_pix_cnt <= w_pix_next;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sh          = r_sh;
   assign f1          = r_f1;
   assign f2          = r_f2;
   assign rs          = r_rs;
   assign line_start  = r_line_start;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Bench for ccd_timing_gen: random line bursts, gap changes and resets; a negedge
// monitor measures the waveform and compares it with per-line expectations from a queue.
module tb_ccd_timing_gen;

   localparam int PIX_DIV    = 20;
   localparam int RS_W       = 2;
   localparam int SH_W       = 100;
   localparam int SH_G       = 20;
   localparam int DUMMY      = 11;
   localparam int PIX        = 64;
   localparam int HALF       = PIX_DIV / 2;
   localparam int LINE_FIXED = 2 * SH_G + SH_W;
   localparam int WAIT_MAX   = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] line_gap;
   logic        sh, f1, f2, rs, line_start, busy;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   ccd_timing_gen #(
      .PIX_DIV    (PIX_DIV),
      .RS_P_WIDTH (RS_W),
      .SH_WIDTH   (SH_W),
      .SH_GUARD   (SH_G),
      .DUMMY_NUM  (DUMMY),
      .PIX_NUM    (PIX)
   ) u_dut (
      .sys_clk     (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .line_gap    (line_gap),
      .sh          (sh),
      .f1          (f1),
      .f2          (f2),
      .rs          (rs),
      .line_start  (line_start),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   int          checks = 0;
   int          errors = 0;
   bit          done   = 1'b0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   bit          in_rst = 1'b0, mon_live = 1'b0;
   bit          f1_valid, f1_had_sh, busy_valid, line_active, arm_rst;
   bit          f2_rise, sh_rise;
   logic        p_sh, p_f1, p_f2, p_rs, p_busy;
   int          cyc, f1_run, rs_run, sh_run, busy_run, exp_busy, f2_cnt, cur_n, line_cyc;
   logic [15:0] g_pop;

   always @(negedge clk) begin
      if (in_rst) begin
         check("reset_outputs", int'({sh, f1, f2, rs, line_start, busy}), int'(6'b010000));
         mon_live    = 1'b1;
         f1_valid    = 1'b0;
         f1_had_sh   = 1'b0;
         busy_valid  = 1'b0;
         line_active = 1'b0;
         arm_rst     = (enable == 1'b1);
         cyc         = 0;
         f1_run      = 1;
         rs_run      = 0;
         sh_run      = 0;
         busy_run    = 0;
         line_cyc    = 0;
      end else if (mon_live) begin
         cyc++;
         line_cyc++;
         f2_rise = f2 && !p_f2;
         sh_rise = sh && !p_sh;
         check("f2_is_not_f1", int'(f2), int'(!f1));

         if (f1 != p_f1) begin
            if (f1_valid) begin
               if (p_f1) check("f1_high_run", f1_run, f1_had_sh ? LINE_FIXED + HALF : HALF);
               else      check("f1_low_run", f1_run, HALF);
            end
            f1_valid  = 1'b1;
            f1_run    = 1;
            f1_had_sh = 1'b0;
         end else begin
            f1_run++;
         end
         if (sh) f1_had_sh = 1'b1;

         if (f2_rise) begin
            check("rs_at_f2_rise", int'(rs), 1);
            if (line_active) f2_cnt++;
         end
         if (rs && !p_rs) begin
            check("rs_rise_with_f2", int'(f2_rise), 1);
            rs_run = 1;
         end else if (rs) begin
            rs_run++;
         end else if (p_rs) begin
            check("rs_width", rs_run, RS_W);
         end

         if (line_start) check("line_start_only_at_sh_rise", int'(sh_rise), 1);

         if (busy && !p_busy) begin
            busy_run   = 1;
            busy_valid = 1'b1;
            exp_busy   = 0;
         end else if (busy) begin
            busy_run++;
         end else if (p_busy) begin
            if (busy_valid) check("busy_length", busy_run, exp_busy);
            if (line_active) check("f2_rises_per_line", f2_cnt, cur_n);
            line_active = 1'b0;
            busy_valid  = 1'b0;
         end

         if (sh_rise) begin
            check("line_start_with_sh", int'(line_start), 1);
            check("busy_at_sh", int'(busy), 1);
            if (f1_valid) check("guard_before_sh", f1_run, SH_G + 1);
            if (line_active) begin
               check("f2_rises_per_line", f2_cnt, cur_n);
               check("line_period", line_cyc, LINE_FIXED + PIX_DIV * cur_n);
            end
            if (arm_rst) check("first_line_after_reset", cyc, PIX_DIV + SH_G + 1);
            arm_rst = 1'b0;
            if (exp_q.size() == 0) begin
               check("unexpected_line", 1, 0);
               g_pop = '0;
            end else begin
               g_pop = exp_q.pop_front();
            end
            cur_n       = DUMMY + PIX + int'(g_pop);
            exp_busy   += LINE_FIXED + PIX_DIV * cur_n;
            line_active = 1'b1;
            f2_cnt      = 0;
            line_cyc    = 0;
            sh_run      = 1;
         end else if (sh) begin
            sh_run++;
         end else if (p_sh) begin
            check("sh_width", sh_run, SH_W);
         end

         if (!enable) arm_rst = 1'b0;
      end
      in_rst = !rst_n;
      p_sh   = sh;
      p_f1   = f1;
      p_f2   = f2;
      p_rs   = rs;
      p_busy = busy;
   end

   // ---------------- driver ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_line_start();
      bit ok = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         @(posedge clk);
         #1;
         if (line_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL line_start_wait: got no line_start in %0d cycles, expected one", WAIT_MAX);
      end
   endtask

   task automatic wait_busy_low();
      bit ok = 1'b0;
      for (int i = 0; i < WAIT_MAX; i++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL busy_low_wait: busy still 1 after %0d cycles, expected 0", WAIT_MAX);
      end
   endtask

   // k back-to-back lines: the first uses gap g0, later ones g1 (changed mid-line).
   task automatic burst(input int k, input int g0, input int g1);
      line_gap = 16'(g0);
      exp_q.push_back(16'(g0));
      enable = 1'b1;
      for (int i = 0; i < k; i++) begin
         wait_line_start();
         tick($urandom_range(800, 300));
         if (i < k - 1) begin
            line_gap = 16'(g1);
            exp_q.push_back(16'(g1));
         end else begin
            line_gap = 16'($urandom_range(65535, 0));
            enable   = 1'b0;
         end
      end
      wait_busy_low();
      tick($urandom_range(50, 3));
   endtask

   task automatic reset_mid(input int delay);
      int g;
      g        = $urandom_range(7, 0);
      line_gap = 16'(g);
      exp_q.push_back(16'(g));
      enable   = 1'b1;
      wait_line_start();
      tick(delay);
      rst_n    = 1'b0;
      g        = $urandom_range(7, 0);
      line_gap = 16'(g);
      exp_q.push_back(16'(g));
      tick(1);
      rst_n    = 1'b1;
      wait_line_start();
      tick($urandom_range(800, 300));
      enable   = 1'b0;
      wait_busy_low();
      tick($urandom_range(50, 3));
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      line_gap = '0;
      tick(5);
      rst_n = 1'b1;
      tick(100);
      burst(1, 0, 0);
      burst(3, 5, 5);
      burst(2, 5, 0);
      reset_mid(10);
      reset_mid(400);
      repeat (3) burst($urandom_range(3, 1), $urandom_range(7, 0), $urandom_range(7, 0));
      tick(10);
      check("expected_queue_empty", exp_q.size(), 0);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      repeat (95000) @(posedge clk);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL watchdog: run exceeded 95000 cycles, expected completion earlier");
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

endmodule

// File: doc/ccd_timing_gen.md
Name: ccd_timing_gen

Overview:
- Generates the linear-CCD clock set (sh, f1, f2, rs) from the 100 MHz sys_clk.
- Sits directly upstream of the AD9945 front-end driver, which takes sh/f2/rs from this block and derives the ADC timing from them.
- One line is: transfer-gate (sh) pulse, then DUMMY_NUM + PIX_NUM + line_gap pixel periods of continuous f1/f2/rs clocking.

Parameters:
- PIX_DIV, 20: sys_clk cycles per pixel period. Must be even and ≥4. Default gives 5 MHz pixel rate.
- RS_P_WIDTH, 2: rs high width in sys_clk cycles. Must satisfy 1 ≤ RS_P_WIDTH < PIX_DIV/2.
- SH_WIDTH, 100: sh high width in sys_clk cycles, ≥1.
- SH_GUARD, 20: cycles of f1=1/f2=0 hold before and after sh, ≥1.
- DUMMY_NUM, 11: dummy pixel periods after sh, before valid pixels.
- PIX_NUM, 2048: valid pixel periods per line.

Ports:
- sys_clk, in, 1: system clock, 100 MHz.
- rst_n, in, 1: synchronous, active-low reset.
- enable, in, 1: start and continue line generation while high.
- line_gap, in, 16: extra pixel periods appended after the valid pixels. Sampled on entry to SH_PRE.
- sh, out, 1: CCD transfer-gate pulse.
- f1, out, 1: CCD shift clock phase 1.
- f2, out, 1: CCD shift clock phase 2. Always the complement of f1.
- rs, out, 1: CCD reset pulse.
- line_start, out, 1: one-cycle pulse on the cycle sh goes high.
- busy, out, 1: high from SH_PRE entry to the end of SHIFT.

Behaviour:
- All outputs are registered. Everything updates on the sys_clk rising edge.
- Reset (rst_n=0 at a clock edge) takes priority over everything else and can occur mid-line. On reset: state=IDLE, ph=0, pix_cnt=0, sh=0, f1=1, f2=0, rs=0, line_start=0, busy=0.
- Phase counter ph runs 0..PIX_DIV-1 and wraps. It runs in IDLE and SHIFT, and is held at 0 in SH_PRE, SH_PULSE and SH_POST.
- Clock decoding in IDLE and SHIFT, on the cycle after the given ph value (one register stage):
  - f1 = 1 for ph < PIX_DIV/2, else 0.
  - f2 = ~f1.
  - rs = 1 for PIX_DIV/2 ≤ ph < PIX_DIV/2 + RS_P_WIDTH.
  - Result: rs rises together with f2.
- States:
  - IDLE: free-running clocks, busy=0. When ph==PIX_DIV-1 and enable==1, latch line_gap and go to SH_PRE.
  - SH_PRE: f1=1, f2=0, rs=0, sh=0 for SH_GUARD cycles, then SH_PULSE.
  - SH_PULSE: sh=1 for SH_WIDTH cycles, with line_start=1 on the first of them. f1/f2/rs held as in SH_PRE. Then SH_POST.
  - SH_POST: sh=0, hold as in SH_PRE for SH_GUARD cycles, then SHIFT with ph=0 and pix_cnt=0.
  - SHIFT: pix_cnt increments at each ph wrap. The line ends at the wrap where pix_cnt == DUMMY_NUM+PIX_NUM+gap_latched-1:
    - if enable=1, go directly to SH_PRE (back-to-back lines);
    - otherwise go to IDLE.
- Counter widths:
  - pix_cnt is 18 bits, so there is no overflow at the maximum of 11+2048+65535.
  - Phase and cycle counters are sized by $clog2 of their parameter.
- Pixel periods per line: SHIFT produces exactly DUMMY_NUM+PIX_NUM+gap f2 rising edges, one per pixel period.
- Line period in sys_clk cycles: 2·SH_GUARD + SH_WIDTH + PIX_DIV·(DUMMY_NUM+PIX_NUM+gap).
- enable deasserted mid-line: the current line completes fully, then IDLE. There are no truncated lines.
- enable reasserted in IDLE: the next SH_PRE starts only at a ph wrap, so f1/f2 never glitch.
- line_gap changes mid-line are ignored until the next SH_PRE entry.
- f1 and f2 are never high simultaneously, in any state, including the reset cycle.

Test Plan:
1. Reset and idle: hold rst_n=0 for 5 cycles, then release with enable=0 -> sh=0, busy=0, f1/f2 toggle every 10 cycles, rs high 2 cycles at each f2 rise, and f1&f2 is never 1.
2. Single line, defaults, line_gap=0: pulse enable high then low -> exactly one sh pulse of 100 cycles, line_start a single cycle coincident with sh rise, 20 cycles guard each side, exactly 2059 f2 rising edges while busy, then IDLE.
3. Back-to-back lines with enable held high and line_gap=5 -> consecutive sh rising edges exactly 20+100+20+20·2064 = 41420 cycles apart.
4. line_gap changed from 5 to 0 mid-SHIFT -> the current line still has 2064 f2 edges; the next line has 2059.
5. Reset mid-SH_PULSE and again mid-SHIFT -> on the following cycle sh=0, f1=1, f2=0, rs=0, busy=0; with enable=1, a new line starts cleanly at the next ph wrap.
6. Small-parameter build with PIX_DIV=4, RS_P_WIDTH=1, SH_WIDTH=3, SH_GUARD=1, DUMMY_NUM=2, PIX_NUM=4 -> busy for exactly 1+3+1+4·6 = 29 cycles, with 6 f2 rises.
